toggle_event_rx: RTL
====================

// Module: toggle_event_rx
// PURPOSE
//  Receive end of the toggle-encoded event link driven by the team's T flip-flop transmitters.
//  Each level change on tog_in marks one event carrying data_in. The block synchronises the
//   toggle, detects the change, captures data into a small FIFO, and returns an ack toggle.
//  Consumers read events over a valid/ready interface; overflow and event count are reported.
// PARAMETERS
//  WIDTH        8   data_in / out_data width in bits
//  DEPTH        4   FIFO entries (power of 2, >=2)
//  SYNC_STAGES  2   flops in tog_in synchroniser (>=2)
//  CNT_W        16  evt_cnt width in bits
// PORTS
//  clk       in   1      clock, all logic on rising edge
//  rst       in   1      reset, synchronous, active-high
//  tog_in    in   1      event toggle from transmitter; each level change = 1 event
//  data_in   in   WIDTH  event payload; transmitter holds it stable until ack_tog changes
//  ack_tog   out  1      toggles once per detected event (accepted or dropped)
//  out_valid out  1      FIFO non-empty
//  out_ready in   1      consumer accepts out_data when out_valid & out_ready
//  out_data  out  WIDTH  head-of-FIFO entry (first-word fall-through)
//  ovf       out  1      sticky: an event was dropped because FIFO was full
//  evt_cnt   out  CNT_W  number of events written into FIFO, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst=1 at an edge): sync chain=0, tog_prev=0, ack_tog=0, FIFO empty,
//   out_valid=0, out_data=0, ovf=0, evt_cnt=0, state=INIT, init counter=0.
//  Reset mid-operation discards all FIFO contents and in-flight events. No partial state remains.
//  FSM states:
//   INIT: runs for SYNC_STAGES+1 cycles after reset release. Synchroniser shifts normally.
//    tog_prev <= sync output each cycle. No events are detected, so a tog_in level held
//    through reset produces no spurious event. Then -> RUN.
//   RUN: evt = sync_out ^ tog_prev. tog_prev <= sync_out every cycle. Stays in RUN until rst.
//  Latency: E0 = first edge that samples the new tog_in level. Push occurs at edge
//   E0+SYNC_STAGES; out_valid is high after that edge. data_in is sampled at the push edge.
//  On evt at an edge:
//   - ack_tog inverts.
//   - If not full, or full with a pop at the same edge: write data_in, evt_cnt+1.
//   - Otherwise: data dropped, ovf<=1, evt_cnt unchanged.
//  Pop = out_valid & out_ready; head advances at the edge.
//  Simultaneous push+pop: occupancy unchanged.
//  Push into an empty FIFO: no combinational bypass; out_valid rises the cycle after the push.
//  out_ready while empty: no effect.
//  Pointers are log2(DEPTH) bits plus a wrap bit. full = same index & different wrap bit.
//   empty = pointers equal.
//  tog_in changing again before ack_tog (protocol violation): each level change seen after
//   sync is one event. Changes shorter than 1 cycle may be lost; no error flag.
//  evt_cnt wraps from 2^CNT_W-1 to 0 silently. ovf clears only on rst.
// TESTING
//  1 Reset, then one tog_in 0->1 with data_in=8'hA5: push 2 edges after E0.
//    out_valid=1, out_data=A5, ack_tog 0->1, evt_cnt=1.
//  2 tog_in=1 held through reset, release: no event in INIT or RUN; evt_cnt=0, ack_tog=0.
//  3 out_ready=0, 5 events (data 1..5), DEPTH=4: FIFO holds 1..4, ovf=1, evt_cnt=4.
//    ack_tog toggled 5 times. Then drain: reads 1,2,3,4, then out_valid=0.
//  4 FIFO full with out_ready=1 at the same edge an event arrives (data 9): pop and push
//    both occur; ovf stays 0; 9 is read last.
//  5 Preset evt_cnt near max (CNT_W=4), 17 events with continuous drain: evt_cnt wraps 15->0->1.
//  6 rst asserted with 3 entries queued and a toggle in the synchroniser: next cycle
//    out_valid=0, evt_cnt=0, ovf=0. No event appears after release.

Source files
------------

// File: rtl/toggle_event_rx_if.sv
// Signal bundle for the toggle-event receive link and its consumer side.
// The master modport is the environment (transmitter plus consumer);
// the slave modport is the receiver block itself.
interface toggle_event_rx_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             tog_in;
    logic [WIDTH-1:0] data_in;
    logic             ack_tog;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             ovf;
    logic [CNT_W-1:0] evt_cnt;

    modport master (
        output tog_in, data_in, out_ready,
        input  ack_tog, out_valid, out_data, ovf, evt_cnt
    );

    modport slave (
        input  tog_in, data_in, out_ready,
        output ack_tog, out_valid, out_data, ovf, evt_cnt
    );
endinterface

// File: rtl/toggle_event_rx.sv
// Receive end of the toggle-encoded event link.
// Each level change of tog_in (after synchronisation) is one event: the
// payload is pushed into a small first-word-fall-through FIFO, an ack toggle
// is returned, and drops on a full FIFO raise a sticky overflow flag.
module toggle_event_rx #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    toggle_event_rx_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(SYNC_STAGES + 2);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                 state_q,    state_d;
    logic [IW-1:0]          init_cnt_q, init_cnt_d;
    logic [SYNC_STAGES-1:0] sync_q,     sync_d;
    logic                   tog_prev_q, tog_prev_d;
    logic                   ack_tog_q,  ack_tog_d;
    logic                   ovf_q,      ovf_d;
    logic [CNT_W-1:0]       evt_cnt_q,  evt_cnt_d;
    logic [AW:0]            wr_ptr_q,   wr_ptr_d;
    logic [AW:0]            rd_ptr_q,   rd_ptr_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];

    logic sync_out;
    logic evt;
    logic empty;
    logic full;
    logic pop;
    logic push;

    // Event detection, FIFO status and the push/pop decisions for this cycle
    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        evt      = (state_q == ST_RUN) && (sync_out ^ tog_prev_q);
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop      = !empty && bus.out_ready;
        push     = evt && (!full || pop);
    end

    // Next-state values: INIT settles tog_prev onto whatever level the
    // synchroniser carries so a level held through reset is not an event
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus.tog_in};
        tog_prev_d = sync_out;
        ack_tog_d  = ack_tog_q;
        ovf_d      = ovf_q;
        evt_cnt_d  = evt_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;

        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == IW'(SYNC_STAGES)) begin
                state_d = ST_RUN;
            end
        end

        if (evt) begin
            ack_tog_d = ~ack_tog_q;
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = bus.data_in;
                wr_ptr_d                = wr_ptr_q + 1'b1;
                evt_cnt_d               = evt_cnt_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // All state registers, cleared together by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            sync_q     <= '0;
            tog_prev_q <= 1'b0;
            ack_tog_q  <= 1'b0;
            ovf_q      <= 1'b0;
            evt_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            sync_q     <= sync_d;
            tog_prev_q <= tog_prev_d;
            ack_tog_q  <= ack_tog_d;
            ovf_q      <= ovf_d;
            evt_cnt_q  <= evt_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.ack_tog   = ack_tog_q;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.ovf       = ovf_q;
    assign bus.evt_cnt   = evt_cnt_q;

endmodule
